// File: rtl/pe_array_pkg.sv
// Shared constants and word types for the PE array routing fabric.
// BCAST_ID is the broadcast tag honoured when ROUTER_BCAST_EN is defined.
package pe_array_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ID_WIDTH   = 8;

    typedef logic [DEF_ID_WIDTH-1:0]   id_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

    localparam id_t BCAST_ID = {DEF_ID_WIDTH{1'b1}};

endpackage

// File: rtl/router_id_match.sv
// Combinational destination match: masked bitwise compare of dest_id against local_id.
// With ROUTER_BCAST_EN defined, an all-ones dest_id hits every configured router.
module router_id_match
    import pe_array_pkg::*;
#(
    parameter int ID_WIDTH = DEF_ID_WIDTH
) (
    input  logic [ID_WIDTH-1:0] dest_id,
    input  logic [ID_WIDTH-1:0] local_id,
    input  logic [ID_WIDTH-1:0] id_mask,
    input  logic                configured,
    output logic                hit
);

    logic [ID_WIDTH-1:0] bit_ok;
    logic                masked_hit;

    // A bit agrees when it is equal or marked don't-care in the mask.
    generate
        for (genvar gi = 0; gi < ID_WIDTH; gi++) begin : g_bit
            assign bit_ok[gi] = ~(dest_id[gi] ^ local_id[gi]) | id_mask[gi];
        end
    endgenerate

    assign masked_hit = &bit_ok;

`ifdef ROUTER_BCAST_EN
    logic bcast_hit;
    assign bcast_hit = (dest_id == {ID_WIDTH{1'b1}});
    assign hit       = configured & (masked_hit | bcast_hit);
`else
    assign hit       = configured & masked_hit;
`endif

endmodule

// File: rtl/pe_router.sv
// Per-PE ingress router: latches ID/mask in config phase, forwards matching bus words in run phase.
// Optional macro ROUTER_BCAST_EN enables the all-ones broadcast destination tag.
module pe_router
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  config_state,
    input  logic                  ce,
    input  logic [ID_WIDTH-1:0]   source_id,
    input  logic [ID_WIDTH-1:0]   dest_id,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic                  bus_data_valid,
    output logic [DATA_WIDTH-1:0] pe_data_in,
    output logic                  pe_data_in_en
);

    logic [ID_WIDTH-1:0]   local_id_reg;
    logic [ID_WIDTH-1:0]   id_mask_reg;
    logic                  configured_reg;
    logic [DATA_WIDTH-1:0] pe_data_reg;
    logic                  pe_en_reg;
    logic                  hit;

    router_id_match #(
        .ID_WIDTH (ID_WIDTH)
    ) u_match (
        .dest_id    (dest_id),
        .local_id   (local_id_reg),
        .id_mask    (id_mask_reg),
        .configured (configured_reg),
        .hit        (hit)
    );

    // rst_n is asserted high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            local_id_reg   <= '0;
            id_mask_reg    <= '0;
            configured_reg <= 1'b0;
            pe_data_reg    <= '0;
            pe_en_reg      <= 1'b0;
        end else if (ce) begin
            if (config_state) begin
                // dest_id doubles as the mask value during configuration.
                local_id_reg   <= source_id;
                id_mask_reg    <= dest_id;
                configured_reg <= 1'b1;
                pe_en_reg      <= 1'b0;
            end else if (bus_data_valid && hit) begin
                pe_data_reg <= bus_data_in;
                pe_en_reg   <= 1'b1;
            end else begin
                pe_en_reg <= 1'b0;
            end
        end else begin
            pe_en_reg <= 1'b0;
        end
    end

    assign pe_data_in    = pe_data_reg;
    assign pe_data_in_en = pe_en_reg;

endmodule

// File: tb/tb_pe_router.sv
// Self-checking bench for pe_router: scoreboard queue of expected deliveries plus a reference model.
// Honours ROUTER_BCAST_EN when computing expected hits.
`timescale 1ns/1ps
module tb_pe_router;
    import pe_array_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  config_state;
    logic  ce;
    id_t   source_id;
    id_t   dest_id;
    data_t bus_data_in;
    logic  bus_data_valid;
    data_t pe_data_in;
    logic  pe_data_in_en;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    id_t   m_local_id;
    id_t   m_mask;
    logic  m_configured;
    data_t m_data;
    data_t exp_q[$];

    pe_router dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .config_state   (config_state),
        .ce             (ce),
        .source_id      (source_id),
        .dest_id        (dest_id),
        .bus_data_in    (bus_data_in),
        .bus_data_valid (bus_data_valid),
        .pe_data_in     (pe_data_in),
        .pe_data_in_en  (pe_data_in_en)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic model_hit(input id_t d);
        logic h;
        h = m_configured && (((d ^ m_local_id) & ~m_mask) == '0);
`ifdef ROUTER_BCAST_EN
        if (m_configured && d == 8'hFF) h = 1'b1;
`endif
        return h;
    endfunction

    task automatic model_reset();
        m_local_id   = '0;
        m_mask       = '0;
        m_configured = 1'b0;
        m_data       = '0;
        exp_q.delete();
    endtask

    // One clock: drive at negedge, update model, check #1 after posedge.
    task automatic step(input string name, input logic cfg, input logic ce_i,
                        input logic valid, input id_t sid, input id_t did, input data_t data);
        data_t got;
        @(negedge clk);
        config_state   = cfg;
        ce             = ce_i;
        valid          = valid;
        bus_data_valid = valid;
        source_id      = sid;
        dest_id        = did;
        bus_data_in    = data;
        if (ce_i && cfg) begin
            m_local_id   = sid;
            m_mask       = did;
            m_configured = 1'b1;
        end else if (ce_i && valid && model_hit(did)) begin
            exp_q.push_back(data);
            m_data = data;
        end
        @(posedge clk);
        #1;
        if (pe_data_in_en === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s: unexpected strobe en=%b data=%h, required en=0", name, pe_data_in_en, pe_data_in);
            end else begin
                got = exp_q.pop_front();
                if (pe_data_in !== got) begin
                    miscompares++;
                    $display("FAIL %s: data got %h required %h", name, pe_data_in, got);
                end
            end
        end else begin
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL %s: strobe missing en=%b, required en=1 data=%h", name, pe_data_in_en, exp_q[0]);
                exp_q.delete();
            end else if (pe_data_in !== m_data) begin
                miscompares++;
                $display("FAIL %s: held data got %h required %h", name, pe_data_in, m_data);
            end
        end
        $display("%s: cfg=%b ce=%b v=%b sid=%h did=%h din=%h -> en=%b dout=%h",
                 name, cfg, ce_i, valid, sid, did, data, pe_data_in_en, pe_data_in);
    endtask

    task automatic check_outputs_zero(input string name);
        vectors++;
        if (pe_data_in !== 16'h0000 || pe_data_in_en !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got data=%h en=%b required data=0000 en=0", name, pe_data_in, pe_data_in_en);
        end
        $display("%s: data=%h en=%b", name, pe_data_in, pe_data_in_en);
    endtask

    task automatic test_reset();
        config_state = 1'b0; ce = 1'b1; source_id = '0; dest_id = 8'h00;
        bus_data_in = 16'hDEAD; bus_data_valid = 1'b1;
        rst_n = 1'b1;
        model_reset();
        #1;
        check_outputs_zero("reset_async");
        repeat (2) begin
            @(posedge clk); #1;
            check_outputs_zero("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b0;
        step("unconfigured_id0", 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 16'hCAFE);
        step("unconfigured_ff",  1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 16'hCAF0);
    endtask

    task automatic test_exact_match();
        step("cfg_05",        1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 16'h0000);
        step("exact_hit",     1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 16'hBEEF);
        step("exact_idle",    1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 16'h1111);
        step("exact_miss",    1'b0, 1'b1, 1'b1, 8'h00, 8'h06, 16'h1234);
        step("invalid_match", 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 16'h2222);
    endtask

    task automatic test_mask_multicast();
        step("cfg_10_mask0f", 1'b1, 1'b1, 1'b0, 8'h10, 8'h0F, 16'h0000);
        step("mask_hit_1a",   1'b0, 1'b1, 1'b1, 8'h00, 8'h1A, 16'hA5A5);
        step("mask_miss_2a",  1'b0, 1'b1, 1'b1, 8'h00, 8'h2A, 16'h5A5A);
        step("mask_hit_10",   1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 16'h0F0F);
        step("mask_miss_90",  1'b0, 1'b1, 1'b1, 8'h00, 8'h90, 16'h9999);
    endtask

    task automatic test_gating();
        step("cfg_05_again",  1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 16'h0000);
        step("ce_off_match",  1'b0, 1'b0, 1'b1, 8'h00, 8'h05, 16'h3333);
        step("ce_off_cfg",    1'b1, 1'b0, 1'b1, 8'h33, 8'hFF, 16'h3434);
        step("after_ce_cfg",  1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 16'h3535);
        step("cfg_with_valid",1'b1, 1'b1, 1'b1, 8'h07, 8'h00, 16'h4444);
        step("reloaded_hit",  1'b0, 1'b1, 1'b1, 8'h00, 8'h07, 16'h4545);
        step("old_id_miss",   1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 16'h4646);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            step("b2b", 1'b0, 1'b1, 1'b1, 8'h00, (i == 3) ? 8'h08 : 8'h07,
                 data_t'($urandom_range(0, 16'hFFFF)));
        end
    endtask

    task automatic test_broadcast();
        step("cfg_05_bc",  1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 16'h0000);
        step("bcast_ff",   1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 16'h7777);
        step("bcast_idle", 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 16'h7878);
        step("cfg_ff",     1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 16'h0000);
        step("ff_exact",   1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 16'h7979);
    endtask

    task automatic test_reset_midop();
        step("cfg_22",  1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 16'h0000);
        step("pre_rst", 1'b0, 1'b1, 1'b1, 8'h00, 8'h22, 16'h8888);
        #2;
        rst_n = 1'b1;
        #1;
        check_outputs_zero("midop_reset_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step("post_rst_unconfigured", 1'b0, 1'b1, 1'b1, 8'h00, 8'h22, 16'h9999);
        step("recfg_22",              1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 16'h0000);
        step("post_rst_hit",          1'b0, 1'b1, 1'b1, 8'h00, 8'h22, 16'hAAAA);
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_mask_multicast();
        test_gating();
        test_back_to_back();
        test_broadcast();
        test_reset_midop();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
